// File: rtl/vga_capture.sv
// Captures the top-left H_CAP x V_CAP window of one incoming VGA frame per start
// command and emits RGB444 frame-buffer write strokes at address y*H_CAP + x.
module vga_capture #(
  parameter int H_CAP  = 512,
  parameter int V_CAP  = 256,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_en,
  input  logic              vid_hs,
  input  logic              vid_vs,
  input  logic              vid_de,
  input  logic [7:0]        vid_r,
  input  logic [7:0]        vid_g,
  input  logic [7:0]        vid_b,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [11:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  localparam int XW = $clog2(H_CAP);
  localparam int YW = $clog2(V_CAP);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
  state_t state, state_nx;

  logic          vs_q, de_q, hs_seen, line_seen;
  logic [XW:0]   x;
  logic [YW:0]   y;
  logic [YW:0]   y_inc, y_after;
  logic          vs_start, de_rise, de_fall;
  logic          in_cap, x_in, y_in, line_end, pix_wr, hs_err;
  logic          unused_low;

  // Stream interface: every input is a sample only on cycles with pix_en high.
  assign vs_start = pix_en & vs_q & ~vid_vs;
  assign de_rise  = pix_en & ~de_q & vid_de;
  assign de_fall  = pix_en & de_q & ~vid_de;

  assign in_cap   = (state == CAPTURE);
  assign x_in     = ~x[XW];
  assign y_in     = ~y[YW];
  assign y_inc    = y_in ? y + 1'b1 : y;
  assign line_end = in_cap & de_fall;
  // A line end coinciding with VS start is accounted for before the VS start.
  assign y_after  = line_end ? y_inc : y;
  assign pix_wr   = in_cap & pix_en & vid_de & x_in & y_in;
  assign hs_err   = in_cap & de_rise & line_seen & hs_seen == 1'b0 & vid_hs;

  assign busy      = (state == WAIT_VS) | (state == CAPTURE);
  assign done      = (state == DONE);
  assign dbg_state = state;
  assign unused_low = ^{vid_r[3:0], vid_g[3:0], vid_b[3:0]};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = WAIT_VS;
      WAIT_VS: if (vs_start) state_nx = CAPTURE;
      CAPTURE: if ((line_end & y_inc[YW]) | vs_start) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      hs_seen <= 1'b0;
    end else if (pix_en) begin
      vs_q    <= vid_vs;
      de_q    <= vid_de;
      hs_seen <= ~vid_hs | (hs_seen & ~de_fall);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      line_seen <= 1'b0;
    end else if (state == WAIT_VS && vs_start) begin
      x         <= '0;
      y         <= '0;
      line_seen <= 1'b0;
    end else if (in_cap && pix_en) begin
      if (vid_de && x_in) x <= x + 1'b1;
      if (de_fall) begin
        x         <= '0;
        y         <= y_inc;
        line_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (state == IDLE && start) begin
      frame_err <= 1'b0;
    end else if (in_cap) begin
      if ((line_end & y_in & x_in) | hs_err | (vs_start & ~y_after[YW]))
        frame_err <= 1'b1;
    end
  end

  // Address and data only move with a write, so they hold while we is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= pix_wr;
      if (pix_wr) begin
        waddr <= {y[YW-1:0], x[XW-1:0]};
        wdata <= {vid_r[7:4], vid_g[7:4], vid_b[7:4]};
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled 16x8 window: synthetic VGA frames, expected
// writes derived from frame geometry, table of frame shapes plus corner sequences.
module tb_vga_capture;

  localparam int H = 16, V = 8, AW = 7;
  localparam int HS_W = 2, HBP = 2, HFP = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, pix_en, vid_hs, vid_vs, vid_de;
  logic [7:0]    vid_r, vid_g, vid_b;
  logic          we, busy, done, frame_err;
  logic [AW-1:0] waddr;
  logic [11:0]   wdata;
  logic [1:0]    dbg_state;

  vga_capture #(.H_CAP(H), .V_CAP(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_en(pix_en),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [AW+11:0] exp_q[$];
  logic [AW+11:0] mon_e;
  int  n_cmp = 0, n_err = 0, wr_cnt = 0, done_cnt = 0, cur_pdiv = 1;
  bit  armed = 1'b0;
  logic we_prev = 1'b0, done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write must be the next expected {addr, data}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", waddr, wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", 32'({waddr, wdata}), 32'(mon_e));
        end
        if (cur_pdiv > 1) check("we_consecutive", 32'(we_prev), 32'd0);
      end
      if (done) begin
        done_cnt++;
        check("done_width", 32'(done_prev), 32'd0);
      end
    end
    we_prev   <= we;
    done_prev <= done;
  end

  task automatic pix(input bit hs, input bit vs, input bit de, input int ln, input int x);
    vid_hs = hs;
    vid_vs = vs;
    vid_de = de;
    vid_r  = 8'($urandom_range(0, 255));
    vid_g  = 8'($urandom_range(0, 255));
    vid_b  = 8'($urandom_range(0, 255));
    if (de && (ln >= V || x >= H)) vid_r = 8'hFF;
    if (de && armed && ln < V && x < H)
      exp_q.push_back({AW'(ln * H + x), vid_r[7:4], vid_g[7:4], vid_b[7:4]});
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    repeat (cur_pdiv - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_line(input int ln, input bit vs, input bit act, input bit hs_pulse, input int len);
    for (int i = 0; i < HS_W; i++) pix(~hs_pulse, vs, 1'b0, ln, 0);
    for (int i = 0; i < HBP; i++)  pix(1'b1, vs, 1'b0, ln, 0);
    for (int i = 0; i < len; i++)  pix(1'b1, vs, act, ln, i);
    for (int i = 0; i < HFP; i++)  pix(1'b1, vs, 1'b0, ln, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Blank line, two VS lines, back porch, then the active lines.
  task automatic send_frame(input int lines, input int len, input int start_line,
                            input int no_hs, input bit arm);
    armed = 1'b0;
    send_line(0, 1'b1, 1'b0, 1'b1, len);
    armed = arm;
    send_line(0, 1'b0, 1'b0, 1'b1, len);
    send_line(0, 1'b0, 1'b0, 1'b1, len);
    send_line(0, 1'b1, 1'b0, 1'b1, len);
    for (int l = 0; l < lines; l++) begin
      if (l == start_line) pulse_start();
      send_line(l, 1'b1, 1'b1, l != no_hs, len);
    end
  endtask

  task automatic settle();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic reset_watch(input int w0);
    int k = 0;
    while (wr_cnt < w0 + 50 && k < 5000) begin @(posedge clk); k++; end
    if (k >= 5000) begin
      n_cmp++;
      n_err++;
      $display("FAIL reset_trigger: got %0d writes, expected at least 50 within bound", wr_cnt - w0);
    end
    #2;
    rst_n = 1'b0;
    armed = 1'b0;
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int lines; int len; int pdiv; int start_line; int no_hs; int exp_writes; bit exp_err;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int w0, d0;
    tbl[0] = '{12, 20, 1, -1, -1, 128, 1'b0};
    tbl[1] = '{12, 20, 4,  2, -1, 128, 1'b0};
    tbl[2] = '{ 8, 16, 1, -1, -1, 128, 1'b0};
    tbl[3] = '{ 5, 20, 1, -1, -1,  80, 1'b1};
    tbl[4] = '{12, 10, 2, -1, -1,  80, 1'b1};
    tbl[5] = '{12, 20, 1, -1,  3, 128, 1'b1};
    tbl[6] = '{12, 20, 3, -1, 10, 128, 1'b0};
    tbl[7] = '{ 7, 16, 1, -1, -1, 112, 1'b1};

    rst_n = 1'b0; start = 1'b0; pix_en = 1'b0;
    vid_hs = 1'b1; vid_vs = 1'b1; vid_de = 1'b0;
    vid_r = '0; vid_g = '0; vid_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_we", 32'(we), 32'd0);
    check("reset_waddr", 32'(waddr), 32'd0);
    check("reset_wdata", 32'(wdata), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    settle();

    for (int i = 0; i < 8; i++) begin
      cur_pdiv = tbl[i].pdiv;
      w0 = wr_cnt;
      d0 = done_cnt;
      pulse_start();
      check("busy_after_start", 32'(busy), 32'd1);
      check("err_cleared", 32'(frame_err), 32'd0);
      send_frame(tbl[i].lines, tbl[i].len, tbl[i].start_line, tbl[i].no_hs, 1'b1);
      send_frame(0, tbl[i].len, -1, -1, 1'b0);
      settle();
      check("writes", 32'(wr_cnt - w0), 32'(tbl[i].exp_writes));
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("frame_err", 32'(frame_err), 32'(tbl[i].exp_err));
      check("busy_end", 32'(busy), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Start in the middle of a frame: capture waits for the next VS.
    cur_pdiv = 1;
    w0 = wr_cnt;
    d0 = done_cnt;
    send_frame(12, 20, 5, -1, 1'b0);
    check("midstart_waiting", 32'(busy), 32'd1);
    check("midstart_no_write", 32'(wr_cnt - w0), 32'd0);
    send_frame(12, 20, -1, -1, 1'b1);
    send_frame(0, 20, -1, -1, 1'b0);
    settle();
    check("midstart_writes", 32'(wr_cnt - w0), 32'd128);
    check("midstart_done", 32'(done_cnt - d0), 32'd1);
    check("midstart_err", 32'(frame_err), 32'd0);

    // Asynchronous reset mid-capture, then a clean capture.
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    fork
      send_frame(12, 20, -1, -1, 1'b1);
      reset_watch(w0);
    join
    send_frame(0, 20, -1, -1, 1'b0);
    settle();
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);
    check("rst_queue", 32'(exp_q.size()), 32'd0);
    w0 = wr_cnt;
    pulse_start();
    send_frame(12, 20, -1, -1, 1'b1);
    send_frame(0, 20, -1, -1, 1'b0);
    settle();
    check("post_rst_writes", 32'(wr_cnt - w0), 32'd128);
    check("post_rst_done", 32'(done_cnt - d0), 32'd1);
    check("post_rst_err", 32'(frame_err), 32'd0);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
